// File: rtl/perf_monitor_pkg.sv
// Shared types and helpers for the pipeline performance monitor.
package perf_monitor_pkg;

    // Run-control state of the monitor.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pm_state_e;

    // A MAX_CYCLES of this value disables the automatic run stop.
    localparam int UNBOUNDED_RUN = 0;

    // Width of the readout select: enough to address every event plus the cycle count.
    function automatic int sel_width(input int num_events);
        return $clog2(num_events + 1);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
// Once the counter sits at all-ones, further increments are dropped and flagged.
module perf_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 ovf_q;
    logic                 ovf_d;

    // Next count: clear wins, otherwise increment or saturate and flag the lost count.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                ovf_d = ovf_q;
            end
        end else begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
        end
    end

    // Counter and overflow registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Performance monitor for the pipelined CPU: counts run cycles and per-cycle
// event strobes into saturating counters, snapshots them into a shadow bank
// and returns one shadow entry per cycle through a registered read port.
module pipeline_perf_monitor
    import perf_monitor_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int MAX_CYCLES = 30
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             clear_i,
    input  logic [NUM_EVENTS-1:0]            event_i,
    input  logic                             snap_i,
    input  logic [sel_width(NUM_EVENTS)-1:0] rd_sel_i,
    output logic [CNT_WIDTH-1:0]             rd_data_o,
    output logic                             running_o,
    output logic                             done_o,
    output logic [NUM_EVENTS:0]              ovf_o
);

    localparam int SEL_W = sel_width(NUM_EVENTS);
    // Cycle count value from which the next counting edge ends the run.
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_CYCLES - 1);

    pm_state_e state_q;
    pm_state_e state_d;

    logic                 count_en_s;
    logic                 max_hit_s;
    logic [NUM_EVENTS:0]  inc_s;
    logic [NUM_EVENTS:0]  ovf_s;
    logic [CNT_WIDTH-1:0] cnt_s    [NUM_EVENTS+1];
    logic [CNT_WIDTH-1:0] shadow_q [NUM_EVENTS+1];
    logic [CNT_WIDTH-1:0] rd_mux_s;
    logic [CNT_WIDTH-1:0] rd_data_q;

    // Counting happens only on edges where the run is active and still enabled.
    assign count_en_s = (state_q == ST_RUN) && start_i;
    // Top bit drives the cycle counter, lower bits the gated event strobes.
    assign inc_s      = {count_en_s, event_i & {NUM_EVENTS{count_en_s}}};
    assign max_hit_s  = (MAX_CYCLES != UNBOUNDED_RUN) && (cnt_s[NUM_EVENTS] == LAST_CNT);

    for (genvar k = 0; k <= NUM_EVENTS; k++) begin : g_cnt
        perf_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (inc_s[k]),
            .cnt_o (cnt_s[k]),
            .ovf_o (ovf_s[k])
        );
    end

    // Run-control next state: clear forces IDLE, DONE holds until cleared.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!start_i) begin
                        state_d = ST_IDLE;
                    end else if (max_hit_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shadow bank captures the live counters as they stood before this edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k <= NUM_EVENTS; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (snap_i) begin
            for (int k = 0; k <= NUM_EVENTS; k++) begin
                shadow_q[k] <= cnt_s[k];
            end
        end else begin
            for (int k = 0; k <= NUM_EVENTS; k++) begin
                shadow_q[k] <= shadow_q[k];
            end
        end
    end

    // Read mux over the shadow bank; selects past the cycle entry return zero.
    always_comb begin
        rd_mux_s = '0;
        for (int k = 0; k <= NUM_EVENTS; k++) begin
            rd_mux_s = rd_mux_s | ((rd_sel_i == SEL_W'(k)) ? shadow_q[k] : '0);
        end
    end

    // Registered readout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_mux_s;
        end
    end

    assign rd_data_o = rd_data_q;
    assign running_o = (state_q == ST_RUN);
    assign done_o    = (state_q == ST_DONE);
    assign ovf_o     = ovf_s;

endmodule
